// File: rtl/mesi_bus_pkg.sv
// Shared encodings for the MESI snooping bus: bus commands, controller FSM states and
// the line-state encoding used by the cache cores.
package mesi_bus_pkg;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_RD   = 3'd1,
    CMD_RDX  = 3'd2,
    CMD_UPGR = 3'd3,
    CMD_WB   = 3'd4
  } bus_cmd_e;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_state_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_SNOOP,
    ST_FLUSH,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_DONE
  } bus_state_e;

  // Codes 5..7 are reserved and behave like NONE.
  function automatic logic cmd_active(input logic [2:0] c);
    return (c != CMD_NONE) && (c <= CMD_WB);
  endfunction

endpackage

// File: rtl/mesi_rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr (cyclically)
// wins; the pointer itself is owned by the caller.
module mesi_rr_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_CORES-1:0] pick,
  output logic [IDX_W-1:0]     pick_idx,
  output logic                 pick_any
);

  logic [NUM_CORES-1:0] rot;

  always_comb begin
    // Rotate so bit 0 is the core the pointer names, then take the first set bit.
    rot      = NUM_CORES'({req, req} >> ptr);
    pick     = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (!pick_any && rot[k]) begin
        pick_any = 1'b1;
        pick_idx = IDX_W'((k + 32'(ptr)) % NUM_CORES);
      end
    end
    if (pick_any) pick = NUM_CORES'(1) << pick_idx;
  end

endmodule

// File: rtl/mesi_snoop_bus_ctrl.sv
// N-core MESI snooping-bus controller: round-robin grant, address broadcast, snoop
// collection, cache-to-cache flush or memory access, then a one-cycle done to the owner.
module mesi_snoop_bus_ctrl import mesi_bus_pkg::*; #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [3*NUM_CORES-1:0]      req_cmd,
  input  logic [ADDR_W*NUM_CORES-1:0] req_addr,
  input  logic [DATA_W*NUM_CORES-1:0] req_wdata,
  output logic [NUM_CORES-1:0]        grant,
  output logic                        bus_valid,
  output logic [2:0]                  bus_cmd,
  output logic [ADDR_W-1:0]           bus_addr,
  output logic [IDX_W-1:0]            bus_src,
  input  logic [NUM_CORES-1:0]        snoop_hit,
  input  logic [NUM_CORES-1:0]        snoop_dirty,
  input  logic [DATA_W*NUM_CORES-1:0] snoop_data,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ready,
  output logic [NUM_CORES-1:0]        done,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        resp_shared,
  output logic                        proto_err
);

  bus_state_e           state_q, state_d;
  logic [NUM_CORES-1:0] eligible, pick, grant_q, hit_m, dirty_m;
  logic [IDX_W-1:0]     pick_idx, src_q, ptr_q, ptr_nxt;
  logic                 pick_any, shared_q, perr_q, multi_dirty, found;
  logic [2:0]           sel_cmd, cmd_q;
  logic [ADDR_W-1:0]    sel_addr, addr_q;
  logic [DATA_W-1:0]    sel_wdata, data_q, flush_data;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++)
      eligible[i] = req[i] && cmd_active(req_cmd[3*i +: 3]);
  end

  mesi_rr_arbiter #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_arb (
    .req      (eligible),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  always_comb begin
    sel_cmd   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (pick[i]) begin
        sel_cmd   = req_cmd[3*i +: 3];
        sel_addr  = req_addr[ADDR_W*i +: ADDR_W];
        sel_wdata = req_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  // The requester's own snoop response is never meaningful, so it is masked out.
  always_comb begin
    hit_m      = snoop_hit & ~grant_q;
    dirty_m    = snoop_dirty & ~grant_q;
    flush_data = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!found && dirty_m[i]) begin
        found      = 1'b1;
        flush_data = snoop_data[DATA_W*i +: DATA_W];
      end
    end
  end

  assign multi_dirty = |(dirty_m & (dirty_m - NUM_CORES'(1)));
  assign ptr_nxt     = (32'(src_q) == NUM_CORES - 1) ? '0 : src_q + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (pick_any) state_d = (sel_cmd == CMD_WB) ? ST_MEM_WR : ST_ADDR;
      ST_ADDR:   state_d = ST_SNOOP;
      ST_SNOOP:
        if (cmd_q == CMD_UPGR) state_d = ST_DONE;
        else if (|dirty_m)     state_d = ST_FLUSH;
        else                   state_d = ST_MEM_RD;
      ST_FLUSH, ST_MEM_RD, ST_MEM_WR: if (mem_ready) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_valid   = (state_q == ST_ADDR);
    mem_req     = (state_q == ST_FLUSH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
    mem_we      = (state_q == ST_FLUSH) || (state_q == ST_MEM_WR);
    mem_addr    = mem_req ? addr_q : '0;
    mem_wdata   = mem_we ? data_q : '0;
    done        = (state_q == ST_DONE) ? grant_q : '0;
    resp_data   = (state_q == ST_DONE) ? data_q : '0;
    resp_shared = (state_q == ST_DONE) && shared_q;
  end

  // data_q holds WB data, then flushed data or the memory fill, whichever the path uses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q  <= '0;
      cmd_q    <= '0;
      addr_q   <= '0;
      src_q    <= '0;
      data_q   <= '0;
      shared_q <= 1'b0;
      ptr_q    <= '0;
      perr_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE:
          if (pick_any) begin
            grant_q  <= pick;
            cmd_q    <= sel_cmd;
            addr_q   <= sel_addr;
            src_q    <= pick_idx;
            data_q   <= (sel_cmd == CMD_WB) ? sel_wdata : '0;
            shared_q <= 1'b0;
          end
        ST_SNOOP: begin
          shared_q <= (cmd_q == CMD_RD) && (|hit_m);
          if (cmd_q != CMD_UPGR && |dirty_m) data_q <= flush_data;
          if (multi_dirty || (cmd_q == CMD_UPGR && |dirty_m)) perr_q <= 1'b1;
        end
        ST_MEM_RD: if (mem_ready) data_q <= mem_rdata;
        ST_DONE: begin
          grant_q <= '0;
          ptr_q   <= ptr_nxt;
        end
        default: ;
      endcase
    end
  end

  assign grant     = grant_q;
  assign bus_cmd   = cmd_q;
  assign bus_addr  = addr_q;
  assign bus_src   = src_q;
  assign proto_err = perr_q;

endmodule
